cpu_multicycle: RTL and testbench
=================================

// Module: cpu_multicycle
// PURPOSE
//  Multi-cycle LEGv8-subset core; successor to the single-cycle CPU. One instruction per 3-5 states
//  with req/ack handshakes to external instruction and data memories, so wait-state memories are supported.
//  Contains its own register file, ALU and FSM; the top level connects it to imem/dmem wrappers.
// PARAMETERS
//  XLEN      64   datapath / register width (>=32)
//  ADDR_W    64   width of pc, imem_addr and dmem_addr (<=XLEN)
//  RESET_PC  0    pc value loaded on reset
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  imem_req     out  1       instruction fetch request, held until imem_ack
//  imem_addr    out  ADDR_W  fetch address (= pc)
//  imem_ack     in   1       fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32      instruction word
//  dmem_req     out  1       data access request, held until dmem_ack
//  dmem_we      out  1       1 = store (STUR), 0 = load (LDUR)
//  dmem_addr    out  ADDR_W  data address (ALU result, truncated)
//  dmem_wdata   out  XLEN    store data (Rt)
//  dmem_ack     in   1       access complete; dmem_rdata valid this cycle for loads
//  dmem_rdata   in   XLEN    load data
//  pc           out  ADDR_W  address of the instruction in flight
//  ALU_result   out  XLEN    registered ALU output of last EXEC
//  retire       out  1       1-cycle pulse when an instruction completes
//  halted       out  1       high in HALT state
//  perf_cycles  out  32      cycles since reset (see CONFIGURATION)
//  perf_retired out  32      instructions retired since reset (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=FETCH, pc=RESET_PC, X0..X30=0, ALU_result=0, all req/we/retire/halted=0,
//    perf counters=0. Reset wins over every other event, incl. mid-handshake (req drops next cycle, ack ignored).
//  - FETCH: imem_req=1; on imem_ack latch IR <= imem_rdata, go DECODE. No ack -> stay, req held.
//  - DECODE: read Rn=IR[9:5], Rm=IR[20:16] (R-type) or Rt=IR[4:0] (STUR/CBZ); sign-extend immediate; classify.
//    Unrecognised opcode -> HALT (pc keeps faulting address, no retire).
//  - EXEC: ALU op, ALU_result registered. R-type -> WB; LDUR/STUR -> MEM; CBZ/B resolve here, retire, -> FETCH.
//  - MEM: dmem_req=1, dmem_we=1 for STUR. On dmem_ack: STUR retires -> FETCH, pc+=4; LDUR latches data -> WB.
//  - WB: write Rd=IR[4:0], retire, pc+=4, -> FETCH.
//  - HALT: terminal; only rst exits. No requests issued.
//  - Decode (IR[31:21] unless noted): ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550, LDUR 0x7C2,
//    STUR 0x7C0, CBZ IR[31:24]=0xB4, B IR[31:26]=0x05.
//  - Immediates: D-type IR[20:12] (9b), CBZ IR[23:5] (19b), B IR[25:0] (26b), sign-extended to XLEN;
//    branch target = pc + (imm<<2), mod 2^ADDR_W (wrap, no trap). Memory address = Xn + imm9, mod 2^ADDR_W.
//  - CBZ taken iff Rt==0; not taken -> pc+4. B always taken.
//  - X31 = XZR: reads 0, writes discarded. Arithmetic mod 2^XLEN, no flags.
//  - Latency with zero-wait memory (ack in the request cycle): R-type 4, STUR 4, LDUR 5, CBZ/B 3 cycles;
//    each wait cycle on imem_ack / dmem_ack adds one.
//  - retire asserts in the final state cycle of each instruction; pc updates on that same edge.
//  - ack while req=0 is ignored. req, addr, we, wdata stable from first request cycle until ack cycle.
// CONFIGURATION
//  CPU_MC_PERF_EN defined: perf_cycles increments every non-reset cycle (incl. HALT), perf_retired on every
//   retire pulse; both wrap at 2^32.
//  CPU_MC_PERF_EN undefined: no counter flops; perf_cycles and perf_retired tied to 0.
// TESTING
//  1 Reset, imem returns ADD X1,X31,X31 (0x8B1F03E1) zero-wait -> retire at cycle 4, X1=0, pc=4.
//  2 Preload X2=5,X3=7; SUB X4,X3,X2 -> ALU_result=2, X4=2; SUB X5,X2,X3 -> X5=0xFFFF_FFFF_FFFF_FFFE.
//  3 STUR X4,[X2,#8] then LDUR X6,[X2,#8], dmem ack delayed 3 cycles -> dmem_addr=13, wdata=2,
//    req held 4 cycles each, X6=2, LDUR takes 8 cycles.
//  4 CBZ X31,#-2 at pc=0x10 -> pc=0x08 after 3 cycles; CBZ X4,#4 with X4=2 -> pc=0x14; B #0x3 -> pc+12.
//  5 Opcode 0xFFFFFFFF -> halted=1, no further imem_req, retire stays 0; rst pulse -> pc=RESET_PC, FETCH.
//  6 rst asserted while dmem_req=1 awaiting ack -> next cycle dmem_req=0, imem_req=1 at RESET_PC;
//    with CPU_MC_PERF_EN, perf_retired==number of retire pulses and counters cleared to 0 by rst.

Source files
------------

// File: rtl/cpu_multicycle.sv
// Multi-cycle LEGv8-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with req/ack
// handshakes to instruction and data memories, internal register file and ALU.
// Optional performance counters are built when CPU_MC_PERF_EN is defined;
// otherwise perf_cycles and perf_retired are tied to zero.
module cpu_multicycle #(
  parameter int unsigned       XLEN     = 64,
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [XLEN-1:0]   ALU_result,
  output logic              retire,
  output logic              halted,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_retired
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
  typedef enum logic [3:0] {
    OpAdd, OpSub, OpAnd, OpOrr, OpLdur, OpStur, OpCbz, OpB, OpIll
  } op_e;

  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

  state_e            state_q, state_d;
  op_e               op;
  logic [31:0]       ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;
  logic [XLEN-1:0]   a_q, b_q, imm_q;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   mdr_q;
  logic [XLEN-1:0]   regs_q [32];
  logic [XLEN-1:0]   rd_a, rd_b, imm_d;
  logic [XLEN-1:0]   wb_data;
  logic [4:0]        rn, rm, rt, b_idx;
  logic              is_rtype, is_mem, is_branch, br_taken;

  assign rn = ir_q[9:5];
  assign rm = ir_q[20:16];
  assign rt = ir_q[4:0];

  // Instruction classification from the latched instruction word.
  always_comb begin
    op = OpIll;
    if (ir_q[31:21] == 11'h458)      op = OpAdd;
    else if (ir_q[31:21] == 11'h658) op = OpSub;
    else if (ir_q[31:21] == 11'h450) op = OpAnd;
    else if (ir_q[31:21] == 11'h550) op = OpOrr;
    else if (ir_q[31:21] == 11'h7C2) op = OpLdur;
    else if (ir_q[31:21] == 11'h7C0) op = OpStur;
    else if (ir_q[31:24] == 8'hB4)   op = OpCbz;
    else if (ir_q[31:26] == 6'h05)   op = OpB;
  end

  assign is_rtype  = (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOrr);
  assign is_mem    = (op == OpLdur) || (op == OpStur);
  assign is_branch = (op == OpCbz) || (op == OpB);
  assign br_taken  = (op == OpB) || ((op == OpCbz) && (b_q == '0));

  // Register read ports; index 31 is XZR and always reads zero.
  always_comb begin
    b_idx = is_rtype ? rm : rt;
    rd_a  = (rn == 5'd31) ? '0 : regs_q[rn];
    rd_b  = (b_idx == 5'd31) ? '0 : regs_q[b_idx];
  end

  // Sign-extended immediate for the decoded format.
  always_comb begin
    imm_d = '0;
    case (op)
      OpLdur, OpStur: imm_d = {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
      OpCbz:          imm_d = {{(XLEN-19){ir_q[23]}}, ir_q[23:5]};
      OpB:            imm_d = {{(XLEN-26){ir_q[25]}}, ir_q[25:0]};
      default:        imm_d = '0;
    endcase
  end

  // ALU: R-type ops, address generation for memory ops, pass-through otherwise.
  always_comb begin
    alu_d = b_q;
    case (op)
      OpAdd:          alu_d = a_q + b_q;
      OpSub:          alu_d = a_q - b_q;
      OpAnd:          alu_d = a_q & b_q;
      OpOrr:          alu_d = a_q | b_q;
      OpLdur, OpStur: alu_d = a_q + imm_q;
      default:        alu_d = b_q;
    endcase
  end

  assign pc_plus4  = pc_q + PcStep;
  // Branch offset is in words; the sum wraps modulo 2^ADDR_W.
  assign br_target = pc_q + {imm_q[ADDR_W-3:0], 2'b00};
  assign wb_data   = (op == OpLdur) ? mdr_q : alu_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (imem_ack) state_d = StDecode;
      StDecode: state_d = (op == OpIll) ? StHalt : StExec;
      StExec: begin
        if (is_rtype)    state_d = StWb;
        else if (is_mem) state_d = StMem;
        else             state_d = StFetch;
      end
      StMem:    if (dmem_ack) state_d = (op == OpStur) ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  // FSM outputs: handshake requests, retire pulse, halt flag.
  always_comb begin
    imem_req = (state_q == StFetch);
    dmem_req = (state_q == StMem);
    dmem_we  = (state_q == StMem) && (op == OpStur);
    halted   = (state_q == StHalt);
    retire   = ((state_q == StExec) && is_branch) ||
               ((state_q == StMem) && dmem_ack && (op == OpStur)) ||
               (state_q == StWb);
  end

  // Instruction register: captured on the fetch handshake only.
  always_ff @(posedge clk) begin
    if (rst)                                ir_q <= '0;
    else if ((state_q == StFetch) && imem_ack) ir_q <= imem_rdata;
  end

  // Operand and immediate latches, loaded in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
    end else if (state_q == StDecode) begin
      a_q   <= rd_a;
      b_q   <= rd_b;
      imm_q <= imm_d;
    end
  end

  // ALU result register, loaded in EXEC.
  always_ff @(posedge clk) begin
    if (rst)                    alu_q <= '0;
    else if (state_q == StExec) alu_q <= alu_d;
  end

  // Load data register, captured on the load handshake.
  always_ff @(posedge clk) begin
    if (rst)                                                      mdr_q <= '0;
    else if ((state_q == StMem) && dmem_ack && (op == OpLdur)) mdr_q <= dmem_rdata;
  end

  // Program counter: advances on the same edge the instruction retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      case (state_q)
        StExec: begin
          if (br_taken)          pc_q <= br_target;
          else if (op == OpCbz)  pc_q <= pc_plus4;
        end
        StMem:   if (dmem_ack && (op == OpStur)) pc_q <= pc_plus4;
        StWb:    pc_q <= pc_plus4;
        default: pc_q <= pc_q;
      endcase
    end
  end

  // Register file write port; writes to XZR are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if ((state_q == StWb) && (rt != 5'd31)) begin
      regs_q[rt] <= wb_data;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_addr  = alu_q[ADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign ALU_result = alu_q;

`ifdef CPU_MC_PERF_EN
  logic [31:0] cyc_cnt_q, ret_cnt_q;

  // Free-running cycle and retire counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (retire) ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign perf_cycles  = cyc_cnt_q;
  assign perf_retired = ret_cnt_q;
`else
  assign perf_cycles  = '0;
  assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench for cpu_multicycle: a table of instructions with their
// memory timing and expected architectural effects, driven through the imem/dmem
// handshakes, plus hand-written halt and reset-during-handshake sequences.
module tb_cpu_multicycle;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [63:0] pc, alu_result;
  logic        retire, halted;
  logic [31:0] perf_cycles, perf_retired;

  cpu_multicycle dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .pc           (pc),
    .ALU_result   (alu_result),
    .retire       (retire),
    .halted       (halted),
    .perf_cycles  (perf_cycles),
    .perf_retired (perf_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    int          iwait;
    int          dwait;
    logic [63:0] ldata;
    int          cycles;
    logic [63:0] pc_next;
    bit          chk_alu;
    logic [63:0] alu;
    bit          is_mem;
    bit          we;
    logic [63:0] maddr;
    logic [63:0] wdata;
    bit          halt;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [31:0] tb_cycles;
  logic [63:0] cur_pc;

  // Reference cycle count: non-reset clock edges since the last reset.
  always @(posedge clk) begin
    if (rst) tb_cycles <= 32'd0;
    else     tb_cycles <= tb_cycles + 32'd1;
  end

  function automatic logic [31:0] enc_r(logic [10:0] op, int rd, int rn, int rm);
    return {op, rm[4:0], 6'b0, rn[4:0], rd[4:0]};
  endfunction

  function automatic logic [31:0] enc_d(logic [10:0] op, int rt, int rn, int imm);
    return {op, imm[8:0], 2'b00, rn[4:0], rt[4:0]};
  endfunction

  function automatic logic [31:0] enc_cbz(int rt, int imm);
    return {8'hB4, imm[18:0], rt[4:0]};
  endfunction

  function automatic logic [31:0] enc_b(int imm);
    return {6'h05, imm[25:0]};
  endfunction

  function automatic vec_t mk(logic [31:0] ir, int iw, int dw, logic [63:0] ld, int cyc,
                              logic [63:0] pcn, bit ca, logic [63:0] alu, bit mem, bit we,
                              logic [63:0] ma, logic [63:0] wd, bit h);
    vec_t v;
    v.ir = ir; v.iwait = iw; v.dwait = dw; v.ldata = ld; v.cycles = cyc;
    v.pc_next = pcn; v.chk_alu = ca; v.alu = alu; v.is_mem = mem; v.we = we;
    v.maddr = ma; v.wdata = wd; v.halt = h;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: reset for two edges, then verify the post-reset state.
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    cur_pc = 64'h0;
    check("rst_imem_req", 64'(imem_req), 64'd1);
    check("rst_pc", pc, 64'h0);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_retire_halted", {62'd0, retire, halted}, 64'd0);
    check("rst_alu", alu_result, 64'h0);
    check("rst_perf", {perf_cycles, perf_retired}, 64'h0);
  endtask

  // Serve one instruction through the handshakes; inputs are driven at negedge.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t        e;
    int          cyc = 0, icnt = 0, dcnt = 0;
    bit          done = 0, saw_ret = 0, unstable = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic        m_we = 1'b0;
    exp_q.push_back(v);
    check($sformatf("v%0d_fetch_addr", idx), imem_addr, cur_pc);
    while (!done && cyc < 60) begin
      cyc++;
      imem_ack = 1'b0; imem_rdata = 32'hFFFF_FFFF;
      dmem_ack = 1'b0; dmem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
      if (imem_req) begin
        if (icnt >= v.iwait) begin
          imem_ack = 1'b1;
          imem_rdata = v.ir;
        end
        icnt++;
      end else begin
        imem_ack = 1'b1;  // stray ack with no request must be ignored
      end
      if (dmem_req) begin
        if (dcnt == 0) begin
          m_addr = dmem_addr; m_we = dmem_we; m_wdata = dmem_wdata;
        end else if (dmem_addr !== m_addr || dmem_we !== m_we || dmem_wdata !== m_wdata) begin
          unstable = 1;
        end
        dcnt++;
        if (dcnt > v.dwait) begin
          dmem_ack = 1'b1;
          dmem_rdata = v.ldata;
        end
      end else begin
        dmem_ack = 1'b1;
      end
      #1;
      if (retire === 1'b1) begin
        saw_ret = 1;
        done = 1;
        pulses++;
      end
      if (halted === 1'b1) done = 1;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("v%0d_completed", idx), 64'(done), 64'd1);
    check($sformatf("v%0d_cycles", idx), 64'(cyc), 64'(e.cycles));
    check($sformatf("v%0d_retired", idx), 64'(saw_ret), 64'(!e.halt));
    check($sformatf("v%0d_halted", idx), 64'(halted), 64'(e.halt));
    check($sformatf("v%0d_pc", idx), pc, e.pc_next);
    if (e.chk_alu) check($sformatf("v%0d_alu", idx), alu_result, e.alu);
    check($sformatf("v%0d_dreq_cycles", idx), 64'(dcnt), e.is_mem ? 64'(e.dwait + 1) : 64'd0);
    if (e.is_mem) begin
      check($sformatf("v%0d_daddr", idx), m_addr, e.maddr);
      check($sformatf("v%0d_dwe", idx), 64'(m_we), 64'(e.we));
      check($sformatf("v%0d_dstable", idx), 64'(unstable), 64'd0);
      if (e.we) check($sformatf("v%0d_dwdata", idx), m_wdata, e.wdata);
    end
    cur_pc = e.pc_next;
  endtask

  initial begin
    int viol;
    int k;
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    cur_pc = '0;

    //          ir                          iw dw ld cyc pc_next  ca alu mem we addr wdata halt
    vecs.push_back(mk(32'h8B1F03E1,           0, 0, 0, 4, 64'h04, 1, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_d(OP_LDUR, 2, 31, 0), 0, 0, 5, 5, 64'h08, 1, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(enc_d(OP_LDUR, 3, 31, 8), 0, 0, 7, 5, 64'h0C, 1, 8,  1, 0, 8, 0, 0));
    vecs.push_back(mk(enc_r(OP_SUB, 4, 3, 2),  0, 0, 0, 4, 64'h10, 1, 2,  0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(OP_SUB, 5, 2, 3),  0, 0, 0, 4, 64'h14, 1,
                      64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_d(OP_STUR, 4, 2, 8), 0, 3, 0, 7, 64'h18, 1, 13, 1, 1, 13, 2, 0));
    vecs.push_back(mk(enc_d(OP_LDUR, 6, 2, 8), 0, 3, 2, 8, 64'h1C, 1, 13, 1, 0, 13, 0, 0));
    vecs.push_back(mk(enc_d(OP_STUR, 6, 31, 16), 0, 1, 0, 5, 64'h20, 1, 16, 1, 1, 16, 2, 0));
    vecs.push_back(mk(enc_d(OP_STUR, 5, 31, 0), 0, 0, 0, 4, 64'h24, 1, 0, 1, 1, 0,
                      64'hFFFF_FFFF_FFFF_FFFE, 0));
    vecs.push_back(mk(enc_r(OP_ADD, 7, 2, 3),  2, 0, 0, 6, 64'h28, 1, 12, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(OP_AND, 8, 7, 3),  0, 0, 0, 4, 64'h2C, 1, 4,  0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(OP_ORR, 9, 8, 31), 0, 0, 0, 4, 64'h30, 1, 4,  0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(OP_ADD, 31, 2, 2), 0, 0, 0, 4, 64'h34, 1, 10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_d(OP_STUR, 31, 2, -5), 0, 0, 0, 4, 64'h38, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(enc_d(OP_STUR, 9, 31, 24), 0, 0, 0, 4, 64'h3C, 1, 24, 1, 1, 24, 4, 0));
    vecs.push_back(mk(enc_cbz(4, 4),            0, 0, 0, 3, 64'h40, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_cbz(31, -2),          0, 0, 0, 3, 64'h38, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_b(3),                 1, 0, 0, 4, 64'h44, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_b(-17),               0, 0, 0, 3, 64'h00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_b(-1),                0, 0, 0, 3, 64'hFFFF_FFFF_FFFF_FFFC,
                      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_cbz(31, 1),           0, 0, 0, 3, 64'h00, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_r(OP_ADD, 10, 5, 3), 0, 0, 0, 4, 64'h04, 1, 5,  0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_cbz(10, 8),           0, 0, 0, 3, 64'h08, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(enc_cbz(13, 2),           0, 0, 0, 3, 64'h10, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'hFFFF_FFFF,            0, 0, 0, 3, 64'h10, 0, 0, 0, 0, 0, 0, 1));

    @(negedge clk);
    do_reset();
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Halted core stays quiet even when offered stray acks.
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'h8B1F03E1;
      dmem_ack = 1'b1;
      #1;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) viol++;
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    check("halt_quiet", 64'(viol), 64'd0);
    check("halt_pc", pc, 64'h10);

    // Reset leaves the halt state and clears the register file.
    do_reset();
    run_vec(100, mk(enc_d(OP_STUR, 4, 2, 3), 0, 0, 0, 4, 64'h04, 1, 3, 1, 1, 3, 0, 0));

    // Reset while a load waits for its data.
    imem_ack = 1'b1; imem_rdata = enc_d(OP_LDUR, 1, 31, 32);
    @(negedge clk);
    imem_ack = 1'b0;
    k = 0;
    while (dmem_req !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("inflight_dreq", 64'(dmem_req), 64'd1);
    repeat (2) @(negedge clk);
    check("inflight_dreq_held", 64'(dmem_req), 64'd1);
`ifdef CPU_MC_PERF_EN
    check("perf_retired", 64'(perf_retired), 64'(pulses));
    check("perf_cycles", 64'(perf_cycles), 64'(tb_cycles));
`else
    check("perf_retired_tied", 64'(perf_retired), 64'd0);
    check("perf_cycles_tied", 64'(perf_cycles), 64'd0);
`endif
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 64'h1234;
    @(negedge clk);
    dmem_ack = 1'b0;
    check("midrst_dmem_req", 64'(dmem_req), 64'd0);
    check("midrst_imem_req", 64'(imem_req), 64'd1);
    check("midrst_imem_addr", imem_addr, 64'h0);
    check("midrst_retire", 64'(retire), 64'd0);
    check("midrst_perf", {perf_cycles, perf_retired}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
